// File: rtl/flyback_ctrl_axil_regs.sv
// AXI4-Lite register block for the flyback converter controller: control, setpoints,
// sticky fault status with interrupt, and the latest output-voltage ADC sample.
module flyback_ctrl_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [3:0]                      fault_in,
  input  logic [11:0]                     vout_sample,
  input  logic                            vout_valid,
  output logic                            ctrl_enable,
  output logic [15:0]                     vref,
  output logic [11:0]                     duty_max,
  output logic                            irq
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam logic [2:0] A_CTRL = 3'd0, A_VREF = 3'd1, A_DUTY = 3'd2, A_STAT = 3'd3,
                         A_MASK = 3'd4, A_VOUT = 3'd5, A_SCR  = 3'd6, A_BAD  = 3'd7;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } w_state_e;
  typedef enum logic { R_IDLE, R_DATA } r_state_e;

  w_state_e        w_state_q;
  r_state_e        r_state_q;
  logic            awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]      bresp_q, rresp_q;
  logic [DW-1:0]   rdata_q;
  logic            aw_have_q, w_have_q;
  logic [2:0]      awidx_q;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   wstrb_q;

  logic            ctrl_q, ctrl_d;
  logic [15:0]     vref_q, vref_d;
  logic [11:0]     duty_q, duty_d;
  logic [3:0]      status_q, status_d;
  logic [3:0]      mask_q, mask_d;
  logic [11:0]     vout_q, vout_d;
  logic [DW-1:0]   scratch_q, scratch_d;
  logic            irq_q, irq_d;

  logic            aw_hs, w_hs, ar_hs, wr_fire, wr_en;
  logic [2:0]      wr_idx, ar_idx;
  logic [DW-1:0]   wr_data, wr_merged;
  logic [SW-1:0]   wr_strb;
  logic [3:0]      status_clr;
  logic [7:0][DW-1:0] regs_v;
  logic            unused_addr_lsbs;

  assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_hs   = S_AXI_AWVALID && awready_q;
  assign w_hs    = S_AXI_WVALID && wready_q;
  assign ar_hs   = S_AXI_ARVALID && arready_q;
  // The write commits on the edge where the second of AW/W is (or already was) captured.
  assign wr_fire = (w_state_q == W_IDLE) && (aw_have_q || aw_hs) && (w_have_q || w_hs);
  assign wr_idx  = aw_have_q ? awidx_q : S_AXI_AWADDR[4:2];
  assign wr_data = w_have_q ? wdata_q : S_AXI_WDATA;
  assign wr_strb = w_have_q ? wstrb_q : S_AXI_WSTRB;
  assign wr_en   = wr_fire && (wr_idx != A_BAD);
  assign ar_idx  = S_AXI_ARADDR[4:2];

  always_comb begin
    regs_v         = '0;
    regs_v[A_CTRL][0]    = ctrl_q;
    regs_v[A_VREF][15:0] = vref_q;
    regs_v[A_DUTY][11:0] = duty_q;
    regs_v[A_STAT][3:0]  = status_q;
    regs_v[A_MASK][3:0]  = mask_q;
    regs_v[A_VOUT][11:0] = vout_q;
    regs_v[A_SCR]        = scratch_q;
  end

  always_comb begin
    wr_merged = regs_v[wr_idx];
    for (int b = 0; b < SW; b++)
      if (wr_strb[b]) wr_merged[8*b +: 8] = wr_data[8*b +: 8];
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    vref_d     = vref_q;
    duty_d     = duty_q;
    mask_d     = mask_q;
    scratch_d  = scratch_q;
    status_clr = '0;
    if (wr_en) begin
      case (wr_idx)
        A_CTRL: ctrl_d    = wr_merged[0];
        A_VREF: vref_d    = wr_merged[15:0];
        A_DUTY: duty_d    = wr_merged[11:0];
        A_STAT: status_clr = wr_strb[0] ? wr_data[3:0] : 4'h0;
        A_MASK: mask_d    = wr_merged[3:0];
        A_SCR:  scratch_d = wr_merged;
        default: ;
      endcase
    end
    // New fault samples win over a simultaneous W1C.
    status_d = (status_q & ~status_clr) | fault_in;
    vout_d   = vout_valid ? vout_sample : vout_q;
    irq_d    = |(status_q & mask_q);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      ctrl_q    <= 1'b0;
      vref_q    <= '0;
      duty_q    <= 12'h800;
      status_q  <= '0;
      mask_q    <= '0;
      vout_q    <= '0;
      scratch_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      vref_q    <= vref_d;
      duty_q    <= duty_d;
      status_q  <= status_d;
      mask_q    <= mask_d;
      vout_q    <= vout_d;
      scratch_q <= scratch_d;
      irq_q     <= irq_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (wr_fire) begin
            w_state_q <= W_RESP;
            bvalid_q  <= 1'b1;
            bresp_q   <= (wr_idx == A_BAD) ? SLVERR : OKAY;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
          end else begin
            if (aw_hs) begin
              aw_have_q <= 1'b1;
              awidx_q   <= S_AXI_AWADDR[4:2];
            end
            if (w_hs) begin
              w_have_q <= 1'b1;
              wdata_q  <= S_AXI_WDATA;
              wstrb_q  <= S_AXI_WSTRB;
            end
            awready_q <= !(aw_have_q || aw_hs);
            wready_q  <= !(w_have_q || w_hs);
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            w_state_q <= W_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase

      case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            r_state_q <= R_DATA;
            rdata_q   <= regs_v[ar_idx];
            rresp_q   <= (ar_idx == A_BAD) ? SLVERR : OKAY;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign ctrl_enable   = ctrl_q && (status_q == 4'h0);
  assign vref          = vref_q;
  assign duty_max      = duty_q;
  assign irq           = irq_q;
endmodule

// File: tb/tb_flyback_ctrl_axil_regs.sv
// Self-checking bench for flyback_ctrl_axil_regs: vector table of write/readback
// pairs plus hand sequences for handshake ordering, faults/irq, errors and reset.
module tb_flyback_ctrl_axil_regs;
  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [4:0]  S_AXI_AWADDR, S_AXI_ARADDR;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic [3:0]  fault_in;
  logic [11:0] vout_sample;
  logic        vout_valid, ctrl_enable, irq;
  logic [15:0] vref;
  logic [11:0] duty_max;

  always #5 ACLK = ~ACLK;

  flyback_ctrl_axil_regs dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .fault_in(fault_in), .vout_sample(vout_sample), .vout_valid(vout_valid),
    .ctrl_enable(ctrl_enable), .vref(vref), .duty_max(duty_max), .irq(irq)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;

  rexp_t sb[$];
  int n_cmp = 0, n_err = 0;

  task automatic step();
    @(posedge ACLK); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic axi_read(input logic [4:0] a, input logic [31:0] ed, input logic [1:0] er,
                          input string nm);
    rexp_t e;
    int t;
    sb.push_back('{ed, er});
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; t = 0;
    while (!S_AXI_ARREADY && t < 50) begin step(); t++; end
    step();
    S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1; t = 0;
    while (!S_AXI_RVALID && t < 50) begin step(); t++; end
    e = sb.pop_front();
    if (!S_AXI_RVALID) chk({nm, "_rvalid_timeout"}, 32'(S_AXI_RVALID), 32'd1);
    else begin
      chk({nm, "_rdata"}, S_AXI_RDATA, e.data);
      chk({nm, "_rresp"}, 32'(S_AXI_RRESP), 32'(e.resp));
    end
    step();
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_lead, input int b_hold, input string nm,
                           output logic [1:0] resp);
    int t;
    logic held;
    fork
      begin
        repeat (w_lead) step();
        S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1; t = 0;
        while (!S_AXI_AWREADY && t < 50) begin step(); t++; end
        step();
        S_AXI_AWVALID = 1'b0;
      end
      begin
        int u;
        S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1; u = 0;
        while (!S_AXI_WREADY && u < 50) begin step(); u++; end
        step();
        S_AXI_WVALID = 1'b0;
      end
    join
    t = 0;
    while (!S_AXI_BVALID && t < 50) begin step(); t++; end
    if (!S_AXI_BVALID) begin
      chk({nm, "_bvalid_timeout"}, 32'(S_AXI_BVALID), 32'd1);
      resp = 2'bxx;
    end else begin
      held = 1'b1;
      repeat (b_hold) begin
        if (!S_AXI_BVALID) held = 1'b0;
        step();
      end
      if (b_hold > 0) chk({nm, "_bvalid_held"}, 32'(held), 32'd1);
      S_AXI_BREADY = 1'b1;
      resp = S_AXI_BRESP;
      step();
      S_AXI_BREADY = 1'b0;
      chk({nm, "_bvalid_clr"}, 32'(S_AXI_BVALID), 32'd0);
    end
  endtask

  vec_t vecs[11];
  logic [1:0] br;
  logic held_ok;

  initial begin
    vecs[0]  = '{5'h00, 32'h0101FFFF, 4'hF, 2'b00, 32'h00000001};
    vecs[1]  = '{5'h04, 32'hABCD0001, 4'hF, 2'b00, 32'h00000001};
    vecs[2]  = '{5'h08, 32'hDEAD0011, 4'hF, 2'b00, 32'h00000011};
    vecs[3]  = '{5'h0C, 32'hBEEF0011, 4'hF, 2'b00, 32'h00000000};
    vecs[4]  = '{5'h10, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h0000000F};
    vecs[5]  = '{5'h14, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h00000000};
    vecs[6]  = '{5'h18, 32'hFFFFFFFF, 4'hF, 2'b00, 32'hFFFFFFFF};
    vecs[7]  = '{5'h18, 32'h00000000, 4'h0, 2'b00, 32'hFFFFFFFF};
    vecs[8]  = '{5'h1C, 32'h5555AAAA, 4'hF, 2'b10, 32'h00000000};
    vecs[9]  = '{5'h13, 32'h00000005, 4'h1, 2'b00, 32'h00000005};
    vecs[10] = '{5'h06, 32'h00001234, 4'h2, 2'b00, 32'h00001201};

    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
    S_AXI_WVALID = 0; S_AXI_BREADY = 0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 0;
    S_AXI_RREADY = 0; fault_in = '0; vout_sample = '0; vout_valid = 0;
    repeat (3) step();
    chk("rst_ready", {28'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, irq}, 32'd0);
    chk("rst_valid", {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 32'd0);
    chk("rst_duty", 32'(duty_max), 32'h800);
    chk("rst_vref_en", {15'd0, ctrl_enable, vref}, 32'd0);
    ARESETN = 1'b1;
    step();
    chk("ready_after_rst", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h7);
    axi_read(5'h08, 32'h800, 2'b00, "rst_duty_rd");

    for (int i = 0; i < 11; i++) begin
      axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 0, 0, $sformatf("v%0d", i), br);
      chk($sformatf("v%0d_bresp", i), 32'(br), 32'(vecs[i].resp));
      axi_read(vecs[i].addr, vecs[i].rdata, vecs[i].resp, $sformatf("v%0d", i));
    end
    chk("out_ports", {ctrl_enable, 3'd0, duty_max, vref}, {1'b1, 3'd0, 12'h011, 16'h1201});

    // W leads AW by three cycles, response stalled by BREADY low.
    axi_write(5'h18, 32'h12345678, 4'h3, 3, 5, "w_first", br);
    chk("w_first_bresp", 32'(br), 32'd0);
    axi_read(5'h18, 32'hFFFF5678, 2'b00, "w_first");

    // Read accepted on the same edge as a write commit sees the old value.
    fork
      axi_write(5'h18, 32'hCAFEF00D, 4'hF, 0, 0, "conc", br);
      axi_read(5'h18, 32'hFFFF5678, 2'b00, "conc_old");
    join
    axi_read(5'h18, 32'hCAFEF00D, 2'b00, "conc_new");

    vout_sample = 12'hABC; vout_valid = 1'b1; step();
    vout_sample = 12'h123; vout_valid = 1'b0; step();
    axi_read(5'h14, 32'h00000ABC, 2'b00, "vout_hold");

    // One-cycle fault pulse latches into STATUS and raises irq.
    axi_write(5'h10, 32'h2, 4'hF, 0, 0, "mask", br);
    axi_write(5'h00, 32'h1, 4'hF, 0, 0, "ctrl", br);
    fault_in = 4'b0010; step();
    fault_in = 4'b0000;
    chk("irq_lag", 32'(irq), 32'd0);
    step();
    chk("irq_set", 32'(irq), 32'd1);
    chk("en_forced_off", 32'(ctrl_enable), 32'd0);
    axi_read(5'h0C, 32'h2, 2'b00, "status_set");
    axi_read(5'h00, 32'h1, 2'b00, "ctrl_kept");
    axi_write(5'h0C, 32'h2, 4'h1, 0, 0, "w1c", br);
    step();
    chk("irq_clr", 32'(irq), 32'd0);
    chk("en_back", 32'(ctrl_enable), 32'd1);
    axi_read(5'h0C, 32'h0, 2'b00, "status_clr");

    // Set wins over a W1C issued while the fault is still asserted.
    fault_in = 4'b0100;
    axi_write(5'h0C, 32'hF, 4'h1, 0, 0, "w1c_vs_set", br);
    fault_in = 4'b0000;
    axi_read(5'h0C, 32'h4, 2'b00, "status_sticky");
    axi_write(5'h0C, 32'hF, 4'h1, 0, 0, "w1c_all", br);
    axi_read(5'h0C, 32'h0, 2'b00, "status_empty");

    // Reset with AW captured and W still pending.
    axi_write(5'h04, 32'h00005A5A, 4'hF, 0, 0, "pre_vref", br);
    axi_write(5'h08, 32'h00000123, 4'hF, 0, 0, "pre_duty", br);
    S_AXI_AWADDR = 5'h04; S_AXI_AWVALID = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0;
    chk("aw_captured", 32'(S_AXI_AWREADY), 32'd0);
    ARESETN = 1'b0;
    step(); step();
    ARESETN = 1'b1;
    held_ok = 1'b1;
    repeat (5) begin
      step();
      if (S_AXI_BVALID) held_ok = 1'b0;
    end
    chk("no_bvalid_after_rst", 32'(held_ok), 32'd1);
    chk("wready_after_rst", 32'(S_AXI_WREADY), 32'd1);
    axi_read(5'h04, 32'h0, 2'b00, "vref_rst");
    axi_read(5'h08, 32'h800, 2'b00, "duty_rst");
    axi_read(5'h18, 32'h0, 2'b00, "scratch_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
